down_counter_timer: RTL and testbench
=====================================

Name: down_counter_timer

Overview:
- Loadable, parameterised down-counter/timer: the count-down counterpart to the team's free-running up-counters.
- Loaded with a period, decrements on enabled cycles, and emits a one-cycle terminal-count pulse on expiry.
- Supports one-shot and auto-reload (continuous) modes.
- Sits beside up-counters in test scripts and servo timing logic, producing periodic strobes and timeouts.

Parameters:
WIDTH, 4, counter and period width in bits.
PRESCALE, 4, enabled cycles per decrement; used only when DOWN_COUNTER_PRESCALE_EN is defined; legal range 2..65536.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  count qualifier; decrement allowed only in cycles where high.
load  input  1  one-cycle strobe: capture load_value and mode, start counting.
load_value  input  WIDTH  period in enabled cycles; 0 is illegal.
mode  input  1  0 = one-shot, 1 = auto-reload; sampled only with load.
stop  input  1  abort the count; return to IDLE.
out  output  WIDTH  current count value (registered).
tc  output  1  terminal-count pulse, exactly one cycle wide (registered).
busy  output  1  high while in RUN.
load_err  output  1  one-cycle pulse when load is attempted with load_value == 0.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: out=0, tc=0, busy=0, load_err=0, reload register=0, stored mode=0, state=IDLE. Reset overrides every other input in the same cycle.
- States:
  - IDLE: out holds its last value.
  - RUN: counting.
  - EXPIRED: one-shot finished; out=0.
- Load: load=1 with load_value!=0, from any state:
  - next cycle out=load_value, reload=load_value, mode stored, state=RUN, busy=1.
  - Load latency is 1 cycle; no decrement occurs in the load cycle.
- Load of zero: load=1 with load_value==0:
  - load_err=1 for the next cycle.
  - state, out, reload and mode unchanged.
- RUN, enable=1, out>1: out <= out-1.
- RUN, enable=1, out==1 (expiry):
  - tc=1 on the next cycle.
  - mode=1: out <= reload; stays in RUN.
  - mode=0: out <= 0; state=EXPIRED; busy=0.
- Period: tc recurs every reload enabled cycles. out never reads 0 in auto-reload mode.
- RUN, enable=0: out holds; no tc.
- EXPIRED: holds until load or reset; enable is ignored; out stays 0.
- stop=1: next cycle state=IDLE, busy=0, out holds its current value, tc=0 (this includes a stop in the expiry cycle).
- Priority: reset > load > stop > decrement/expiry.
  - load and expiry in the same cycle: load wins, tc not asserted.
  - load and stop in the same cycle: load wins.
- tc and load_err are never held longer than one cycle.
- Arithmetic: unsigned, modulo 2^WIDTH. Maximum period 2^WIDTH-1. No underflow is reachable because expiry is detected at out==1.

Optional Feature:
- DOWN_COUNTER_PRESCALE_EN defined:
  - Adds an internal prescale counter of width clog2(PRESCALE).
  - Prescale counter advances on enabled cycles only; a decrement/expiry occurs only on the enabled cycle where it equals PRESCALE-1, after which it wraps to 0.
  - Prescale counter clears on reset, load and stop.
  - Period becomes reload*PRESCALE enabled cycles.
- DOWN_COUNTER_PRESCALE_EN undefined:
  - No prescaler logic; PRESCALE is unused.
  - Every enabled cycle is a decrement opportunity.

Test Plan:
- Reset, then load=1, load_value=5, mode=0, enable held high -> out 5,4,3,2,1,0 on successive cycles; tc=1 only in the cycle out first reads 0; busy falls at the same time; state EXPIRED.
- load_value=3, mode=1, enable high for 12 cycles -> out cycles 3,2,1,3,2,1,...; tc pulses every 3rd cycle, 4 pulses total; busy stays 1.
- load_value=4, mode=1, enable toggling 1,0,1,0,... -> out decrements only on enable=1 cycles; tc period 8 clocks.
- load=1 with load_value=0 while RUN at out=2 -> load_err pulse for 1 cycle; out, busy and count progression unaffected.
- Auto-reload, load_value=7, assert load (value 9) in the same cycle out==1 -> no tc; next out=9. Separately, reset asserted mid-count at out=6 -> out=0, busy=0, tc=0 the next cycle.
- With DOWN_COUNTER_PRESCALE_EN, PRESCALE=4, load_value=2, mode=0, enable high -> tc asserted 8 cycles after the load cycle; out reads 2 for 4 cycles, then 1 for 4 cycles.

Source files
------------

// File: rtl/down_counter_timer_if.sv
// Control/status bundle for down_counter_timer.
// master drives the controls and reads status; slave is the timer side.
interface down_counter_timer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             mode;
  logic             stop;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             busy;
  logic             load_err;

  modport master (
    output enable, load, load_value, mode, stop,
    input  out, tc, busy, load_err
  );

  modport slave (
    input  enable, load, load_value, mode, stop,
    output out, tc, busy, load_err
  );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with one-shot and auto-reload modes.
// Emits a one-cycle tc pulse on expiry; load_err flags a zero-period load.
// Optional prescaler enabled by defining DOWN_COUNTER_PRESCALE_EN
// (PRESCALE enabled cycles per decrement); the default build has none.
module down_counter_timer #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  down_counter_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  // Reject illegal prescale settings at elaboration time.
  generate
    if (PRESCALE < 2 || PRESCALE > 65536) begin : g_bad_prescale
      $error("down_counter_timer: PRESCALE must be in 2..65536");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] reload_q;
  logic             mode_q;
  logic             tc_q;
  logic             busy_q;
  logic             load_err_q;
  logic             load_ok_c;
  logic             tick_c;

  assign load_ok_c = bus.load && (bus.load_value != '0);

`ifdef DOWN_COUNTER_PRESCALE_EN
  localparam int unsigned PSC_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);

  logic [PSC_W-1:0] psc_q;

  // Decrement opportunity only on the enabled cycle that completes a prescale period.
  always_comb begin
    tick_c = bus.enable && (psc_q == PSC_MAX);
  end

  // Prescale counter: advances while running and enabled; cleared by reset, load and stop.
  always_ff @(posedge clk) begin
    if (reset || load_ok_c || bus.stop) begin
      psc_q <= '0;
    end else if (state == RUN && bus.enable) begin
      if (psc_q == PSC_MAX) begin
        psc_q <= '0;
      end else begin
        psc_q <= psc_q + PSC_W'(1);
      end
    end
  end
`else
  // Every enabled cycle is a decrement opportunity.
  always_comb begin
    tick_c = bus.enable;
  end
`endif

  // Main FSM: reset > valid load > stop > decrement/expiry; zero loads only raise load_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      out_q      <= '0;
      reload_q   <= '0;
      mode_q     <= 1'b0;
      tc_q       <= 1'b0;
      busy_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      tc_q       <= 1'b0;
      load_err_q <= bus.load && (bus.load_value == '0);
      if (load_ok_c) begin
        state    <= RUN;
        out_q    <= bus.load_value;
        reload_q <= bus.load_value;
        mode_q   <= bus.mode;
        busy_q   <= 1'b1;
      end else if (bus.stop) begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end else if (state == RUN && tick_c) begin
        if (out_q == WIDTH'(1)) begin
          tc_q <= 1'b1;
          if (mode_q) begin
            out_q <= reload_q;
          end else begin
            out_q  <= '0;
            state  <= EXPIRED;
            busy_q <= 1'b0;
          end
        end else begin
          out_q <= out_q - WIDTH'(1);
        end
      end
    end
  end

  assign bus.out      = out_q;
  assign bus.tc       = tc_q;
  assign bus.busy     = busy_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: the driver pushes hand-computed
// expected outputs per cycle, a separate monitor pops and compares them.
module tb_down_counter_timer;

  localparam int unsigned WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             busy;
    logic             err;
    string            name;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   n_vec;
  int   n_bad;

  down_counter_timer_if #(.WIDTH(WIDTH)) bus ();

  down_counter_timer #(.WIDTH(WIDTH), .PRESCALE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at negedge and queue the outputs expected after the next posedge.
  task automatic step(input logic rst, input logic en, input logic ld,
                      input logic [WIDTH-1:0] lv, input logic md, input logic sp,
                      input logic [WIDTH-1:0] e_out, input logic e_tc,
                      input logic e_busy, input logic e_err, input string name);
    exp_t e;
    @(negedge clk);
    reset          = rst;
    bus.enable     = en;
    bus.load       = ld;
    bus.load_value = lv;
    bus.mode       = md;
    bus.stop       = sp;
    e.out  = e_out;
    e.tc   = e_tc;
    e.busy = e_busy;
    e.err  = e_err;
    e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle; compare one queued vector per cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        n_vec++;
        if (bus.out !== e.out || bus.tc !== e.tc || bus.busy !== e.busy ||
            bus.load_err !== e.err) begin
          n_bad++;
          $display("FAIL %s: got out=%0d tc=%b busy=%b load_err=%b, want out=%0d tc=%b busy=%b load_err=%b",
                   e.name, bus.out, bus.tc, bus.busy, bus.load_err,
                   e.out, e.tc, e.busy, e.err);
        end
      end
    end
  end

  initial begin
    int budget;
    n_vec = 0;
    n_bad = 0;
    reset          = 1'b1;
    bus.enable     = 1'b0;
    bus.load       = 1'b0;
    bus.load_value = '0;
    bus.mode       = 1'b0;
    bus.stop       = 1'b0;

    //   rst en ld lv md sp   out tc busy err
    step(1, 0, 0, 0, 0, 0,    0, 0, 0, 0, "reset0");
    step(1, 1, 1, 5, 1, 0,    0, 0, 0, 0, "reset_over_load");
    step(0, 0, 1, 0, 0, 0,    0, 0, 0, 1, "zero_load_idle");
    step(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, "zero_load_clear");

`ifdef DOWN_COUNTER_PRESCALE_EN
    step(0, 1, 1, 2, 0, 0,    2, 0, 1, 0, "psc_load");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 2, 0, 1, 0, "psc_hold2");
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, "psc_hold1");
    step(0, 1, 0, 0, 0, 0,    0, 1, 0, 0, "psc_expire");
    step(0, 1, 0, 0, 0, 0,    0, 0, 0, 0, "psc_expired_hold");
`else
    // One-shot from 5
    step(0, 1, 1, 5, 0, 0,    5, 0, 1, 0, "os_load");
    step(0, 1, 0, 0, 0, 0,    4, 0, 1, 0, "os_4");
    step(0, 1, 0, 0, 0, 0,    3, 0, 1, 0, "os_3");
    step(0, 1, 0, 0, 0, 0,    2, 0, 1, 0, "os_2");
    step(0, 1, 0, 0, 0, 0,    1, 0, 1, 0, "os_1");
    step(0, 1, 0, 0, 0, 0,    0, 1, 0, 0, "os_expire");
    step(0, 1, 0, 0, 0, 0,    0, 0, 0, 0, "os_expired_hold");
    step(0, 1, 0, 0, 0, 0,    0, 0, 0, 0, "os_expired_hold2");

    // Auto-reload period 3, twelve enabled cycles -> four tc pulses
    step(0, 1, 1, 3, 1, 0,    3, 0, 1, 0, "ar3_load");
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 0, 0,  2, 0, 1, 0, "ar3_2");
      step(0, 1, 0, 0, 0, 0,  1, 0, 1, 0, "ar3_1");
      step(0, 1, 0, 0, 0, 0,  3, 1, 1, 0, "ar3_reload");
    end

    // Auto-reload period 4 with enable toggling -> tc every 8 clocks
    step(0, 0, 1, 4, 1, 0,    4, 0, 1, 0, "ar4_load");
    step(0, 1, 0, 0, 0, 0,    3, 0, 1, 0, "ar4_3");
    step(0, 0, 0, 0, 0, 0,    3, 0, 1, 0, "ar4_3h");
    step(0, 1, 0, 0, 0, 0,    2, 0, 1, 0, "ar4_2");
    step(0, 0, 0, 0, 0, 0,    2, 0, 1, 0, "ar4_2h");
    step(0, 1, 0, 0, 0, 0,    1, 0, 1, 0, "ar4_1");
    step(0, 0, 0, 0, 0, 0,    1, 0, 1, 0, "ar4_1h");
    step(0, 1, 0, 0, 0, 0,    4, 1, 1, 0, "ar4_reload");
    step(0, 0, 0, 0, 0, 0,    4, 0, 1, 0, "ar4_4h");
    step(0, 1, 0, 0, 0, 0,    3, 0, 1, 0, "ar4_3b");
    step(0, 0, 0, 0, 0, 0,    3, 0, 1, 0, "ar4_3bh");
    step(0, 1, 0, 0, 0, 0,    2, 0, 1, 0, "ar4_2b");
    step(0, 0, 0, 0, 0, 0,    2, 0, 1, 0, "ar4_2bh");
    step(0, 1, 0, 0, 0, 0,    1, 0, 1, 0, "ar4_1b");
    step(0, 0, 0, 0, 0, 0,    1, 0, 1, 0, "ar4_1bh");
    step(0, 1, 0, 0, 0, 0,    4, 1, 1, 0, "ar4_reload2");

    // Zero load while running at out=2: count continues, reload/mode kept
    step(0, 1, 0, 0, 0, 0,    3, 0, 1, 0, "zl_3");
    step(0, 1, 0, 0, 0, 0,    2, 0, 1, 0, "zl_2");
    step(0, 1, 1, 0, 0, 0,    1, 0, 1, 1, "zl_err");
    step(0, 1, 0, 0, 0, 0,    4, 1, 1, 0, "zl_reload");

    // Load wins over expiry in the same cycle
    step(0, 1, 1, 7, 1, 0,    7, 0, 1, 0, "lx_load7");
    for (int v = 6; v >= 1; v--) step(0, 1, 0, 0, 0, 0, WIDTH'(v), 0, 1, 0, "lx_down");
    step(0, 1, 1, 9, 1, 0,    9, 0, 1, 0, "lx_load9");
    step(0, 1, 0, 0, 0, 0,    8, 0, 1, 0, "lx_8");

    // Stop holds out and drops busy; IDLE ignores enable
    step(0, 1, 0, 0, 0, 1,    8, 0, 0, 0, "stop_hold");
    step(0, 1, 0, 0, 0, 0,    8, 0, 0, 0, "idle_hold");

    // Stop in the expiry cycle suppresses tc
    step(0, 1, 1, 2, 1, 0,    2, 0, 1, 0, "sx_load");
    step(0, 1, 0, 0, 0, 0,    1, 0, 1, 0, "sx_1");
    step(0, 1, 0, 0, 0, 1,    1, 0, 0, 0, "sx_stop");

    // Load and stop together: load wins
    step(0, 1, 1, 3, 0, 1,    3, 0, 1, 0, "ls_load");

    // Reset mid-count at out=6
    step(0, 1, 1, 8, 0, 0,    8, 0, 1, 0, "rm_load");
    step(0, 1, 0, 0, 0, 0,    7, 0, 1, 0, "rm_7");
    step(0, 1, 0, 0, 0, 0,    6, 0, 1, 0, "rm_6");
    step(1, 1, 0, 0, 0, 0,    0, 0, 0, 0, "rm_reset");

    // Maximum period one-shot
    step(0, 1, 1, 15, 0, 0,  15, 0, 1, 0, "max_load");
    for (int v = 14; v >= 1; v--) step(0, 1, 0, 0, 0, 0, WIDTH'(v), 0, 1, 0, "max_down");
    step(0, 1, 0, 0, 0, 0,    0, 1, 0, 0, "max_expire");
    step(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, "max_tc_clear");
`endif

    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
